// File: rtl/video_scan_counter_pkg.sv
// Shared timing constants and helpers for the character-rate video scan counter.
// H is {HPE, H5..H0}; V is {V5..V0, VC, VB, VA}.
package video_scan_counter_pkg;

  localparam logic [6:0] H_PRESET    = 7'h40;
  localparam logic [6:0] H_LAST      = 7'h7F;
  localparam logic [6:0] H_VIS       = 7'h58;
  localparam logic [6:0] HSYNC_START = 7'h49;
  localparam logic [6:0] HSYNC_END   = 7'h4C;

  localparam logic [8:0] V_START_NTSC = 9'h0FA;
  localparam logic [8:0] V_START_PAL  = 9'h0C8;
  localparam logic [8:0] V_LAST       = 9'h1FF;
  localparam logic [8:0] VBL_END      = 9'h100;
  localparam logic [8:0] VBL_START    = 9'h1C0;
  localparam logic [8:0] VSYNC_START  = 9'h1E0;
  localparam logic [8:0] VSYNC_END    = 9'h1E3;

  function automatic logic [8:0] v_start(input logic pal);
    return pal ? V_START_PAL : V_START_NTSC;
  endfunction

endpackage

// File: rtl/video_scan_counter_cnt4_sync.sv
// 4-bit synchronous counter with parallel load, EP/ET enables and ripple-free TC.
// The asynchronous clear forces a per-instance value so frame counters can reset to their start line.
module cnt4_sync #(
  parameter logic [3:0] ClrVal = 4'h0
) (
  input  logic       clk,
  input  logic       clr,
  input  logic       load,
  input  logic       ep,
  input  logic       et,
  input  logic [3:0] d,
  output logic [3:0] q,
  output logic       tc
);

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      q <= ClrVal;
    end else if (load) begin
      q <= d;
    end else if (ep && et) begin
      q <= q + 4'd1;
    end
  end

  assign tc = et && (q == 4'hF);

endmodule

// File: rtl/video_scan_counter.sv
// Horizontal/vertical scan counter built from cascaded cnt4_sync stages,
// with registered blank/sync decodes aligned to the counter values.
module video_scan_counter
  import video_scan_counter_pkg::*;
#(
  parameter bit PAL = 1'b0
) (
  input  logic       CLK,
  input  logic       CLR,
  input  logic       CE,
  output logic [6:0] H,
  output logic [8:0] V,
  output logic       HBL,
  output logic       VBL,
  output logic       HSYNC,
  output logic       VSYNC,
  output logic       HTC,
  output logic       VTC
);

  localparam logic [8:0] VS = v_start(PAL);

  logic [3:0] hl_q, hh_q, vl_q, vm_q, vh_q;
  logic       hl_tc, hh_tc, vl_tc, vm_tc, vh_tc;
  logic       h_load, v_load;
  logic [6:0] h_load_val, h_next;
  logic [8:0] v_next;

  assign H = {hh_q[2:0], hl_q};
  assign V = {vh_q[0], vm_q, vl_q};

  assign HTC = CE && (H == H_LAST);
  assign VTC = HTC && (V == V_LAST);

  // Any value outside the 0x40..0x7F run (including the unused top bit) re-enters at the preset.
  assign h_load     = CE && (!hh_q[2] || hh_q[3] || (H == H_LAST));
  assign h_load_val = ((H == H_LAST) && !hh_q[3]) ? 7'h00 : H_PRESET;
  assign v_load     = HTC && ((V == V_LAST) || (V < VS) || (|vh_q[3:1]));

  cnt4_sync #(.ClrVal(4'h0)) u_h_lo (
    .clk(CLK), .clr(CLR), .load(h_load), .ep(CE), .et(1'b1),
    .d(h_load_val[3:0]), .q(hl_q), .tc(hl_tc)
  );

  cnt4_sync #(.ClrVal(4'h0)) u_h_hi (
    .clk(CLK), .clr(CLR), .load(h_load), .ep(CE), .et(hl_tc),
    .d({1'b0, h_load_val[6:4]}), .q(hh_q), .tc(hh_tc)
  );

  cnt4_sync #(.ClrVal(VS[3:0])) u_v_lo (
    .clk(CLK), .clr(CLR), .load(v_load), .ep(HTC), .et(1'b1),
    .d(VS[3:0]), .q(vl_q), .tc(vl_tc)
  );

  cnt4_sync #(.ClrVal(VS[7:4])) u_v_mid (
    .clk(CLK), .clr(CLR), .load(v_load), .ep(HTC), .et(vl_tc),
    .d(VS[7:4]), .q(vm_q), .tc(vm_tc)
  );

  cnt4_sync #(.ClrVal({3'b000, VS[8]})) u_v_hi (
    .clk(CLK), .clr(CLR), .load(v_load), .ep(HTC), .et(vm_tc),
    .d({3'b000, VS[8]}), .q(vh_q), .tc(vh_tc)
  );

  // Decodes are taken from the next counter value so they settle on the same edge as H/V.
  always_comb begin
    h_next = H;
    if (h_load) begin
      h_next = h_load_val;
    end else if (CE) begin
      h_next = H + 7'd1;
    end
    v_next = V;
    if (v_load) begin
      v_next = VS;
    end else if (HTC) begin
      v_next = V + 9'd1;
    end
  end

  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      HBL   <= 1'b1;
      VBL   <= 1'b1;
      HSYNC <= 1'b0;
      VSYNC <= 1'b0;
    end else begin
      HBL   <= h_next < H_VIS;
      VBL   <= (v_next < VBL_END) || (v_next >= VBL_START);
      HSYNC <= (h_next >= HSYNC_START) && (h_next <= HSYNC_END);
      VSYNC <= (v_next >= VSYNC_START) && (v_next <= VSYNC_END);
    end
  end

  logic unused_tc;
  assign unused_tc = hh_tc ^ vh_tc;

endmodule
